// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types and constants for the data-memory responder.
package riscv_mem_pkg;
  typedef enum logic [0:0] {LOAD = 1'b0, RUN = 1'b1} state_e;
  localparam int DMEM_DEPTH_DEFAULT = 64;
  localparam logic [31:0] CYCLE_CNT_ADDR = 32'hFFFF_FFFC;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/data_mem_responder_ld_byte_packer.sv
// ld_byte_packer: packs accepted preload bytes little-endian into 32-bit words.
module ld_byte_packer
  import riscv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_accept,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  output logic        o_word_valid,
  output logic [31:0] o_word_out,
  output logic        o_word_last
);
  logic [1:0]  r_cnt;
  logic [31:0] r_pack;
  // upper bytes of r_pack stay zero, so a short final word is zero-filled for free
  assign o_word_out   = r_pack | (32'(i_data) << {r_cnt, 3'b000});
  assign o_word_valid = i_accept && (r_cnt == 2'(WORD_BYTES - 1) || i_last);
  assign o_word_last  = i_accept && i_last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt  <= '0;
      r_pack <= '0;
    end else if (o_word_valid) begin
      r_cnt  <= '0;
      r_pack <= '0;
    end else if (i_accept) begin
      r_cnt  <= r_cnt + 2'd1;
      r_pack <= o_word_out;
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: core data-memory responder with byte-stream preload and cpu_run release.
// Optional cycle counter at 32'hFFFF_FFFC enabled by DMEM_CYCLE_CNT_EN.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_run,
  output logic        err_misalign,
  output logic        err_range,
  output logic        ld_overflow
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  state_e           r_state;
  logic [IDX_W-1:0] r_ld_ptr;
  logic [31:0]      r_mem [DEPTH_WORDS];
  logic             r_err_misalign, r_err_range, r_ld_overflow;
  logic             w_accept, w_commit, w_last;
  logic [31:0]      w_word;
  logic             w_in_range, w_misalign, w_store, w_store_ok, w_is_cnt;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_cnt_val;
  assign ld_ready     = (r_state == LOAD);
  assign cpu_run      = (r_state == RUN);
  assign err_misalign = r_err_misalign;
  assign err_range    = r_err_range;
  assign ld_overflow  = r_ld_overflow;
  assign w_accept     = ld_valid && ld_ready;
  ld_byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_accept    (w_accept),
    .i_data      (ld_data),
    .i_last      (ld_last),
    .o_word_valid(w_commit),
    .o_word_out  (w_word),
    .o_word_last (w_last)
  );
  assign w_in_range = (aluout[31:IDX_W+2] == '0);
  assign w_idx      = aluout[IDX_W+1:2];
  assign w_misalign = (aluout[1:0] != 2'b00);
  assign w_store    = cpu_run && memwrite;
  assign w_store_ok = w_store && !w_misalign && w_in_range;
`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] r_cycles;
  assign w_is_cnt  = (aluout[31:2] == CYCLE_CNT_ADDR[31:2]);
  assign w_cnt_val = r_cycles;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cycles <= '0;
    else if (cpu_run) r_cycles <= r_cycles + 32'd1;
`else
  assign w_is_cnt  = 1'b0;
  assign w_cnt_val = '0;
`endif
  assign readdata = !cpu_run ? '0 : w_is_cnt ? w_cnt_val : w_in_range ? r_mem[w_idx] : '0;
  always_ff @(posedge clk)
    if (w_commit) r_mem[r_ld_ptr] <= w_word;
    else if (w_store_ok) r_mem[w_idx] <= writedata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state        <= LOAD;
      r_ld_ptr       <= '0;
      r_err_misalign <= 1'b0;
      r_err_range    <= 1'b0;
      r_ld_overflow  <= 1'b0;
    end else begin
      if (w_commit) begin
        r_ld_ptr <= r_ld_ptr + 1'b1;
        if (w_last || r_ld_ptr == IDX_W'(DEPTH_WORDS - 1)) r_state <= RUN;
        if (!w_last && r_ld_ptr == IDX_W'(DEPTH_WORDS - 1)) r_ld_overflow <= 1'b1;
      end
      if (w_store && w_misalign) r_err_misalign <= 1'b1;
      if (w_store && !w_in_range && !w_is_cnt) r_err_range <= 1'b1;
    end
endmodule
